// File: rtl/gcd_host_pkg.sv
// Shared types and sizing helpers for the GCD host-side initiator.
package gcd_host_pkg;

  // Transaction sequencer states: wait for a command, present operands, await the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Default queue depth and the matching pointer width.
  localparam int unsigned GCD_DEPTH = 4;
  localparam int unsigned PTR_W     = $clog2(GCD_DEPTH);

  // Pointer width for an arbitrary depth, never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/gcd_fifo.sv
// Small synchronous FIFO with a registered head and full/empty flags.
// The producer may push only while !full; the consumer may pop only while !empty.
// The head reads as zero while the FIFO is empty.
module gcd_fifo
  import gcd_host_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = GCD_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_val,
  input  logic [W-1:0] push_data,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = ptr_width(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push_fire, pop_fire;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign push_fire = push_val & ~full;
  assign pop_fire  = pop_rdy & ~empty;
  assign pop_data  = empty ? '0 : mem_q[rd_ptr_q];

  // Occupancy follows the push/pop combination of this cycle.
  always_comb begin
    count_d = count_q;
    unique case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage write port; contents need no reset since the flags qualify them.
  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and occupancy registers; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_fire)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gcd_host_if.sv
// Host-side initiator for the GCD val/rdy operand/result protocol.
// Commands are queued, issued one at a time, and results are queued for the host.
// Only one transaction is ever outstanding, so responses keep command order.
module gcd_host_if
  import gcd_host_pkg::*;
#(
  parameter int unsigned WL    = 8,
  parameter int unsigned DEPTH = GCD_DEPTH
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic [WL-1:0] cmd_a,
  input  logic [WL-1:0] cmd_b,
  input  logic          cmd_val,
  output logic          cmd_rdy,
  output logic [WL-1:0] op_a,
  output logic [WL-1:0] op_b,
  output logic          ops_val,
  input  logic          ops_rdy,
  input  logic [WL-1:0] res,
  input  logic          res_val,
  output logic          res_rdy,
  output logic [WL-1:0] rsp_data,
  output logic          rsp_val,
  input  logic          rsp_rdy,
  output logic          busy,
  output logic [7:0]    done_count
);

  state_t          state_q, state_d;
  logic [7:0]      done_count_q, done_count_d;
  logic [2*WL-1:0] cmd_head;
  logic            cmd_full, cmd_empty;
  logic            rsp_full, rsp_empty;
  logic            ops_fire, res_fire;

  // Operand pairs waiting to be issued; {a, b} packed in one entry.
  gcd_fifo #(.W(2*WL), .DEPTH(DEPTH)) u_cmd_q (
    .clk       (clk),
    .rst_n     (rst_b),
    .push_val  (cmd_val),
    .push_data ({cmd_a, cmd_b}),
    .pop_rdy   (ops_fire),
    .pop_data  (cmd_head),
    .full      (cmd_full),
    .empty     (cmd_empty)
  );

  // Results waiting for the host.
  gcd_fifo #(.W(WL), .DEPTH(DEPTH)) u_rsp_q (
    .clk       (clk),
    .rst_n     (rst_b),
    .push_val  (res_fire),
    .push_data (res),
    .pop_rdy   (rsp_rdy),
    .pop_data  (rsp_data),
    .full      (rsp_full),
    .empty     (rsp_empty)
  );

  // The queue head is registered storage, so operands stay stable until popped.
  assign op_a       = cmd_head[2*WL-1:WL];
  assign op_b       = cmd_head[WL-1:0];
  // Gating with rst_b keeps the host from pushing while reset is held.
  assign cmd_rdy    = rst_b & ~cmd_full;
  assign ops_val    = (state_q == ISSUE);
  assign res_rdy    = (state_q == WAIT) & ~rsp_full;
  assign rsp_val    = ~rsp_empty;
  assign ops_fire   = ops_val & ops_rdy;
  assign res_fire   = res_val & res_rdy;
  assign busy       = (state_q != IDLE) | ~cmd_empty;
  assign done_count = done_count_q;

  // Next-state logic for the single-outstanding transaction sequencer.
  always_comb begin
    state_d      = state_q;
    done_count_d = done_count_q;
    unique case (state_q)
      IDLE:  if (!cmd_empty) state_d = ISSUE;
      ISSUE: if (ops_fire)   state_d = WAIT;
      WAIT: begin
        if (res_fire) begin
          state_d      = IDLE;
          done_count_d = done_count_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and completed-result counter.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      done_count_q <= done_count_d;
    end
  end

endmodule
